puf_resp_serializer: RTL

- Upstream feeder for the UART transmitter.
- Latches a 64-bit PUF response word and breaks it into bytes.
- Hands each byte to the UART tx side using its transmit/is_transmitting handshake, one byte at a time until the word is sent.
- Reports busy/done/error to the PUF controller.

---
 rtl/puf_resp_serializer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/puf_resp_serializer.sv
// Serializes a latched 64-bit PUF response into bytes for a UART transmitter.
// Define PUF_SER_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module puf_resp_serializer #(
  parameter int NUM_BYTES   = 8,
  parameter int MSB_FIRST   = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] resp_word,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        is_transmitting,
`ifdef PUF_SER_CHECKSUM_EN
  output logic [3:0]  byte_idx
`else
  output logic [2:0]  byte_idx
`endif
);

`ifdef PUF_SER_CHECKSUM_EN
  localparam int IDX_W = 4;
`else
  localparam int IDX_W = 3;
`endif
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(ACK_TIMEOUT);
  localparam int ALIGN = 64 - 8 * NUM_BYTES;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(NUM_BYTES - 1);
`ifdef PUF_SER_CHECKSUM_EN
  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(NUM_BYTES);
`else
  localparam logic [IDX_W-1:0] FINAL_IDX = LAST_DATA;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    PULSE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [63:0]       shift_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [7:0]        tx_byte_r;
  logic              transmit_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              timeout_s;
  logic              advance_s;
  logic [7:0]        data_byte_s;
  logic [7:0]        sel_byte_s;
`ifdef PUF_SER_CHECKSUM_EN
  logic [7:0]        csum_r;
`endif

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign tx_byte  = tx_byte_r;
  assign transmit = transmit_r;
  assign byte_idx = idx_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic, timeout detection and byte advance decision.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !is_transmitting) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD:  next_state_s = PULSE;
      PULSE: next_state_s = WAIT_ACK;
      WAIT_ACK: begin
        if (is_transmitting) begin
          next_state_s = WAIT_DONE;
        end else if (cnt_r >= CNT_LAST) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (is_transmitting) begin
          next_state_s = WAIT_DONE;
        end else if (idx_r == FINAL_IDX) begin
          next_state_s = FINISH;
        end else begin
          next_state_s = LOAD;
          advance_s    = 1'b1;
        end
      end
      FINISH:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Byte selection: the outgoing data byte always sits at one end of the shift register.
  always_comb begin
    data_byte_s = (MSB_FIRST != 0) ? shift_r[63:56] : shift_r[7:0];
`ifdef PUF_SER_CHECKSUM_EN
    if (idx_r == FINAL_IDX) begin
      sel_byte_s = csum_r;
    end else begin
      sel_byte_s = data_byte_s;
    end
`else
    sel_byte_s = data_byte_s;
`endif
  end

  // Datapath: word capture, shifting, byte index, timeout counter, checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= 64'h0;
      cnt_r     <= '0;
      idx_r     <= '0;
      tx_byte_r <= 8'h00;
`ifdef PUF_SER_CHECKSUM_EN
      csum_r    <= 8'h00;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (next_state_s == LOAD) begin
            // Left-align the used bytes so MSB-first always drains from bit 63.
            shift_r <= (MSB_FIRST != 0) ? (resp_word << ALIGN) : resp_word;
            idx_r   <= '0;
`ifdef PUF_SER_CHECKSUM_EN
            csum_r  <= 8'h00;
`endif
          end
        end
        LOAD: begin
          tx_byte_r <= sel_byte_s;
`ifdef PUF_SER_CHECKSUM_EN
          if (idx_r != FINAL_IDX) begin
            csum_r <= csum_r ^ data_byte_s;
          end
`endif
        end
        PULSE: cnt_r <= '0;
        WAIT_ACK: begin
          if (!is_transmitting && (cnt_r < CNT_SAT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (advance_s) begin
            shift_r <= (MSB_FIRST != 0) ? {shift_r[55:0], 8'h00} : {8'h00, shift_r[63:8]};
            idx_r   <= idx_r + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status and handshake outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      transmit_r <= 1'b0;
    end else begin
      busy_r     <= (next_state_s != IDLE) && (next_state_s != FINISH);
      done_r     <= (next_state_s == FINISH);
      err_r      <= timeout_s;
      transmit_r <= (next_state_s == PULSE);
    end
  end

endmodule
